fifo_rr_enq_arb: RTL

FIFO_RR_ENQ_ARB -- requirements
Module: fifo_rr_enq_arb

---
 rtl/fifo_rr_enq_arb.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fifo_rr_enq_arb.sv
// fifo_rr_enq_arb
//   Four-requester round-robin write arbiter in front of a FIFO, with a
//   fill/drain read controller and an optional contention counter.
//
//   Parameters
//     DW        data width per requester
//     DEPTH_LOG log2 of FIFO depth
//     RD_THR    fill level that starts draining (1..2^DEPTH_LOG)
//
//   Ports
//     CLK, RST   clock (posedge), asynchronous active-high reset
//     req, din   per-requester level request and packed data ([i*DW +: DW])
//     gnt        one-hot combinational accept
//     fifo_enq   registered enqueue strobe, fifo_din registered data
//     fifo_deq   combinational dequeue strobe (DRAIN only)
//     rd_rdy     downstream consumer ready
//     occ        resident entry count, draining = DRAIN state
//     stall_cnt  cycles with a pending request and no grant
//
//   Build option: define FIFO_RR_ENQ_ARB_STAT_EN to build the stall counter;
//   otherwise stall_cnt is tied to zero.
module fifo_rr_enq_arb #(
  parameter int DW        = 32,
  parameter int DEPTH_LOG = 12,
  parameter int RD_THR    = 3072
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [3:0]           req,
  input  logic [4*DW-1:0]      din,
  output logic [3:0]           gnt,
  output logic                 fifo_enq,
  output logic [DW-1:0]        fifo_din,
  output logic                 fifo_deq,
  input  logic                 rd_rdy,
  output logic [DEPTH_LOG:0]   occ,
  output logic                 draining,
  output logic [15:0]          stall_cnt
);

  localparam int OW = DEPTH_LOG + 1;
  // Depth expressed one bit wider than occ so occ + enq never wraps.
  localparam logic [OW:0]   DEPTH_W = {1'b0, 1'b1, {DEPTH_LOG{1'b0}}};
  localparam logic [OW-1:0] THR_W   = RD_THR[OW-1:0];
  localparam logic [OW-1:0] ONE_W   = {{(OW-1){1'b0}}, 1'b1};

  typedef enum logic {S_FILL, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic [1:0]      p_q, p_d;
  logic            enq_q;
  logic [DW-1:0]   din_q, din_d;
  logic [OW-1:0]   occ_q, occ_d;

  logic            room;
  logic            win_vld;
  logic [1:0]      win;
  logic            grant;

  // Room counts the enqueue already in flight so the FIFO can never overfill.
  assign room = ({1'b0, occ_q} + {{OW{1'b0}}, enq_q}) < DEPTH_W;

  // Round-robin scan starting at p; descending loop so the closest index wins.
  always_comb begin
    logic [1:0] idx;
    idx     = p_q;
    win_vld = 1'b0;
    win     = p_q;
    for (int k = 3; k >= 0; k--) begin
      idx = p_q + 2'(k);
      if (req[idx]) begin
        win_vld = 1'b1;
        win     = idx;
      end
    end
  end

  // Gate with RST so the combinational accept is quiet while held in reset.
  assign grant = win_vld && room && !RST;
  assign gnt   = grant ? (4'b0001 << win) : 4'b0000;

  assign fifo_deq = (state_q == S_DRAIN) && rd_rdy && (occ_q != '0) && !RST;

  always_comb begin
    p_d   = p_q;
    din_d = din_q;
    if (grant) begin
      p_d   = win + 2'd1;
      din_d = din[win*DW +: DW];
    end
  end

  always_comb begin
    occ_d = occ_q;
    case ({enq_q, fifo_deq})
      2'b10:   occ_d = occ_q + ONE_W;
      2'b01:   occ_d = occ_q - ONE_W;
      default: occ_d = occ_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FILL:  if (occ_q >= THR_W) state_d = S_DRAIN;
      // Only leave DRAIN on a true underrun: empty with nothing landing.
      S_DRAIN: if ((occ_q == '0) && !enq_q) state_d = S_FILL;
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_FILL;
      p_q     <= 2'd0;
      enq_q   <= 1'b0;
      din_q   <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      enq_q   <= grant;
      din_q   <= din_d;
      occ_q   <= occ_d;
    end
  end

  assign fifo_enq = enq_q;
  assign fifo_din = din_q;
  assign occ      = occ_q;
  assign draining = (state_q == S_DRAIN);

`ifdef FIFO_RR_ENQ_ARB_STAT_EN
  logic [15:0] stall_q;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      stall_q <= '0;
    else if ((req != 4'b0000) && !grant && (stall_q != 16'hFFFF))
      stall_q <= stall_q + 16'd1;
  end
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule
